// File: rtl/array_sort_check_datapath.sv
`default_nettype none
// ============================================================================
// Module      : array_sort_check_datapath
// Description : Datapath half of the sort-check engine. Holds the array under
//               test, the element-count (length) register and the scan index,
//               and reports whether the pair at index/index+1 is out of order
//               and whether any pair remains to be checked.
//
// Ports       : clock           rising-edge clock
//               reset           asynchronous reset, active low
//               wr_en           array write strobe
//               wr_addr         array write address
//               wr_data         array write data
//               length_in       number of valid elements, sampled on load_input
//               load_input      capture length_in into the length register
//               load_index      update the index register
//               select_index    0: index <- 0, 1: index <- index + 1 (saturating)
//               inversion_found mem[index] > mem[index+1] for a valid pair
//               end_of_array    no pair remains at the current index
//               index           current scan index
//
// Revision    : 1.0 - initial release
// ============================================================================
module array_sort_check_datapath #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH:0]   length_in,
  input  logic                  load_input,
  input  logic                  load_index,
  input  logic                  select_index,
  output logic                  inversion_found,
  output logic                  end_of_array,
  output logic [ADDR_WIDTH-1:0] index
);

  localparam int                  c_DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_DEPTH_L   = c_DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] c_IDX_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] c_ONE_A   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   c_ONE_L   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [ADDR_WIDTH:0]   r_length;
  logic [ADDR_WIDTH-1:0] r_index;

  logic [ADDR_WIDTH-1:0] w_addr_b;
  logic [DATA_WIDTH-1:0] w_rd_a;
  logic [DATA_WIDTH-1:0] w_rd_b;
  logic [ADDR_WIDTH:0]   w_next_pos;
  logic                  w_end;
  logic                  w_gt;

  // Array storage: contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Length register, clamped to the array depth.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_length <= '0;
    end else if (load_input) begin
      if (length_in > c_DEPTH_L) begin
        r_length <= c_DEPTH_L;
      end else begin
        r_length <= length_in;
      end
    end
  end

  // Scan index: clear or saturating increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_index <= '0;
    end else if (load_index) begin
      if (!select_index) begin
        r_index <= '0;
      end else if (r_index != c_IDX_MAX) begin
        r_index <= r_index + c_ONE_A;
      end
    end
  end

  // Second read port wraps modulo depth; any wrapped pair is masked by w_end.
  assign w_addr_b = r_index + c_ONE_A;
  assign w_rd_a   = r_mem[r_index];
  assign w_rd_b   = r_mem[w_addr_b];

  // Evaluated one bit wider so index 2^ADDR_WIDTH-1 + 1 does not overflow.
  assign w_next_pos = {1'b0, r_index} + c_ONE_L;
  assign w_end      = (w_next_pos >= r_length);

  generate
    if (SIGNED_CMP) begin : g_signed_cmp
      assign w_gt = ($signed(w_rd_a) > $signed(w_rd_b));
    end else begin : g_unsigned_cmp
      assign w_gt = (w_rd_a > w_rd_b);
    end
  endgenerate

  assign end_of_array    = w_end;
  assign inversion_found = ~w_end & w_gt;
  assign index           = r_index;

endmodule
`default_nettype wire

// File: tb/tb_array_sort_check_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_array_sort_check_datapath
// Description : Self-checking bench for array_sort_check_datapath. Drives a
//               signed-compare and an unsigned-compare instance from the same
//               stimulus: a directed vector table, hand-written reset/clamp
//               sequences and a randomized phase checked against a
//               behavioural model of the array, length and index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_array_sort_check_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  length_in;
  logic        load_input;
  logic        load_index;
  logic        select_index;

  logic        inv_s, eoa_s, inv_u, eoa_u;
  logic [4:0]  idx_s, idx_u;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_mem [32];
  int          m_len;
  int          m_idx;

  always #5 clk = ~clk;

  array_sort_check_datapath #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SIGNED_CMP(1'b1)) dut_s (
    .clock(clk), .reset(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .length_in(length_in), .load_input(load_input), .load_index(load_index),
    .select_index(select_index), .inversion_found(inv_s), .end_of_array(eoa_s),
    .index(idx_s)
  );

  array_sort_check_datapath #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SIGNED_CMP(1'b0)) dut_u (
    .clock(clk), .reset(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .length_in(length_in), .load_input(load_input), .load_index(load_index),
    .select_index(select_index), .inversion_found(inv_u), .end_of_array(eoa_u),
    .index(idx_u)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [5:0]  li;
    logic        ldi;
    logic        ldx;
    logic        sel;
    logic [4:0]  e_idx;
    logic        e_eoa;
    logic        e_inv_s;
    logic        e_inv_u;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [5:0] li, input logic ldi, input logic ldx,
                              input logic sel, input logic [4:0] e_idx, input logic e_eoa,
                              input logic e_inv_s, input logic e_inv_u);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.li = li; v.ldi = ldi; v.ldx = ldx; v.sel = sel;
    v.e_idx = e_idx; v.e_eoa = e_eoa; v.e_inv_s = e_inv_s; v.e_inv_u = e_inv_u;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] e_idx, input logic e_eoa,
                         input logic e_inv_s, input logic e_inv_u);
    chk({tag, ".idx_s"}, 32'(idx_s), 32'(e_idx));
    chk({tag, ".eoa_s"}, 32'(eoa_s), 32'(e_eoa));
    chk({tag, ".inv_s"}, 32'(inv_s), 32'(e_inv_s));
    chk({tag, ".idx_u"}, 32'(idx_u), 32'(e_idx));
    chk({tag, ".eoa_u"}, 32'(eoa_u), 32'(e_eoa));
    chk({tag, ".inv_u"}, 32'(inv_u), 32'(e_inv_u));
  endtask

  // Expected outputs derived from the model: a pair exists when index+1 < length.
  task automatic chk_model(input string tag);
    logic e_eoa, e_s, e_u;
    e_eoa = (m_idx + 1 >= m_len);
    e_s = 1'b0;
    e_u = 1'b0;
    if (!e_eoa) begin
      e_s = (int'(m_mem[m_idx]) > int'(m_mem[m_idx+1]));
      e_u = (m_mem[m_idx] > m_mem[m_idx+1]);
    end
    chk_all(tag, 5'(m_idx), e_eoa, e_s, e_u);
  endtask

  // One clock cycle: inputs change on the falling edge, model follows the
  // rising edge, outputs are sampled 1 time unit later.
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [5:0] li, input logic ldi, input logic ldx, input logic sel);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; length_in = li;
    load_input = ldi; load_index = ldx; select_index = sel;
    @(posedge clk);
    if (we) m_mem[wa] = wd;
    if (ldi) m_len = (int'(li) > 32) ? 32 : int'(li);
    if (ldx) begin
      if (!sel) m_idx = 0;
      else if (m_idx < 31) m_idx = m_idx + 1;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234; length_in = 6'd20;
    load_input = 1'b1; load_index = 1'b1; select_index = 1'b1;
    m_len = 0; m_idx = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;

    // Reset applied at time 0 takes effect before the first rising edge.
    #3;
    chk_all("reset_async", 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    wr_en = 1'b0; load_input = 1'b0; load_index = 1'b0; select_index = 1'b0;
    rst_n = 1'b1;
    idle();
    chk_all("reset_hold", 5'd0, 1'b1, 1'b0, 1'b0);

    // ---------------- directed vector table ----------------
    // sorted {1,3,3,7,9}
    tbl.push_back(mk(1, 0, 32'd1, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 32'd3, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 2, 32'd3, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 32'd7, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4, 32'd9, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'd0, 5, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'd0, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'd0, 0, 0, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'd0, 0, 0, 1, 1, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'd0, 0, 0, 1, 1, 4, 1, 0, 0));
    // {-2,5,4,8}: signed sees 5>4 at index 1, unsigned also 0xFFFFFFFE>5 at 0
    tbl.push_back(mk(1, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 1, 32'd5, 0, 0, 0, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 2, 32'd4, 0, 0, 0, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 3, 32'd8, 0, 0, 0, 0, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'd0, 4, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'd0, 0, 0, 1, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 32'd0, 0, 0, 0, 0, 1, 0, 1, 1));
    // {1, 0xFFFFFFFF}: signed 1 > -1, unsigned not
    tbl.push_back(mk(1, 0, 32'd1, 0, 0, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'd0, 2, 1, 1, 0, 0, 0, 1, 0));
    // length 0 and 1
    tbl.push_back(mk(0, 0, 32'd0, 0, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'd0, 1, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'd0, 0, 0, 1, 1, 1, 1, 0, 0));
    // write hazard: {10,20,30}, then mem[2] <- 5 while index = 1
    tbl.push_back(mk(1, 0, 32'd10, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 32'd20, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 2, 32'd30, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'd0, 3, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'd0, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 2, 32'd5, 0, 0, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 32'd0, 0, 0, 0, 0, 1, 0, 1, 1));

    foreach (tbl[k]) begin
      step(tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].li, tbl[k].ldi, tbl[k].ldx, tbl[k].sel);
      chk_all($sformatf("vec%0d", k), tbl[k].e_idx, tbl[k].e_eoa, tbl[k].e_inv_s, tbl[k].e_inv_u);
    end

    // ---------------- length clamp and index saturation ----------------
    for (int i = 0; i < 32; i++) step(1'b1, 5'(i), 32'(2 * i), 6'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 6'd40, 1'b1, 1'b1, 1'b0);
    chk_all("clamp_start", 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 5'd0, 32'd0, 6'd0, 1'b0, 1'b1, 1'b1);
      chk_all($sformatf("clamp_idx%0d", i), 5'(i), (i == 31), 1'b0, 1'b0);
    end
    step(1'b0, 5'd0, 32'd0, 6'd0, 1'b0, 1'b1, 1'b1);
    chk_all("saturate", 5'd31, 1'b1, 1'b0, 1'b0);

    // ---------------- mid-scan asynchronous reset ----------------
    step(1'b0, 5'd0, 32'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 6'd0, 1'b0, 1'b1, 1'b1);
    chk_all("pre_reset", 5'd3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    load_index = 1'b0; select_index = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_idx = 0; m_len = 0;
    chk_all("midscan_reset", 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk_all("post_reset_hold", 5'd0, 1'b1, 1'b0, 1'b0);

    // ---------------- randomized phase against the model ----------------
    for (int i = 0; i < 32; i++) step(1'b1, 5'(i), $urandom, 6'd0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      step(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), d,
           6'($urandom_range(0, 63)), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) != 0));
      chk_model($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/array_sort_check_datapath.md
Name: array_sort_check_datapath

Overview:
- Datapath partner of the sort-check control FSM. Holds the array under test, the length register and the scan index.
- Consumes the FSM's load_input, load_index and select_index. Returns inversion_found and end_of_array.
- The array is filled through a write port before go is raised. Contents are compared pairwise at index and index+1.

Parameters:
- DATA_WIDTH, 32, element width in bits.
- ADDR_WIDTH, 5, index/address width; array depth = 2^ADDR_WIDTH (32).
- SIGNED_CMP, 1, 1 = elements compared as two's-complement signed, 0 = unsigned.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wr_en  in  1  array write strobe.
- wr_addr  in  ADDR_WIDTH  array write address.
- wr_data  in  DATA_WIDTH  array write data.
- length_in  in  ADDR_WIDTH+1  number of valid elements; sampled on load_input.
- load_input  in  1  from FSM: capture length_in.
- load_index  in  1  from FSM: update index register.
- select_index  in  1  from FSM: 0 = index<-0, 1 = index<-index+1.
- inversion_found  out  1  mem[index] > mem[index+1], valid pair only.
- end_of_array  out  1  no pair remains at current index.
- index  out  ADDR_WIDTH  current scan index (offending position after an unsorted result).

Behaviour:
- Reset (reset==0, asynchronous): index=0, length=0.
  - Outputs after reset: end_of_array=1, inversion_found=0.
  - Array contents are not reset; they are undefined until written.
- Array storage:
  - 2^ADDR_WIDTH x DATA_WIDTH registers, synchronous write on the rising edge when wr_en=1.
  - Two asynchronous read ports: addr A = index, addr B = index+1 (ADDR_WIDTH bits, wraps modulo depth).
  - A write to an address being read becomes visible combinationally only after that edge.
- Length register:
  - On the edge with load_input=1, length <- min(length_in, 2^ADDR_WIDTH).
  - Otherwise length holds.
- Index register:
  - On the edge with load_index=1: index <- 0 if select_index=0, else index+1.
  - If index=2^ADDR_WIDTH-1 and an increment is requested, index holds (saturates, no wrap).
  - If load_index=0, index holds.
- Simultaneous load_input and load_index on the same edge: both update independently. The new length and new index are used together from the next cycle.
- end_of_array = ((index + 1) >= length), computed combinationally at ADDR_WIDTH+1 bits with zero extension.
  - length 0 or 1 therefore gives end_of_array=1 at index 0.
- inversion_found = ~end_of_array && (mem[A] > mem[B]).
  - The comparison is signed or unsigned per SIGNED_CMP.
  - Equal elements are not an inversion.
  - Forced 0 whenever end_of_array=1, so a wrapped B address never reports.
- Cycle relation with the FSM:
  - The FSM samples inversion_found in its judge state and increments index in the same cycle.
  - Both outputs are pure functions of registered state, so they settle within the cycle after each edge.
  - There are no combinational paths from load_* or select_index to the outputs.
- Writes during a scan are legal. The result reflects the contents present at each comparison cycle.
- Reset asserted mid-scan: immediately returns index=0 and length=0. end_of_array rises without waiting for a clock edge.

Test Plan:
- Reset: reset=0 with arbitrary inputs -> index=0, end_of_array=1, inversion_found=0 with no clock edge; hold after release until loads occur.
- Sorted array: write {1,3,3,7,9}, length_in=5, load_input=1, load_index=1, select_index=0, then 4 increments:
  - inversion_found=0 at every index.
  - end_of_array=0 for index 0..3, and 1 at index 4.
- Unsorted, signed: SIGNED_CMP=1, write {-2,5,4,8}, length 4, scan:
  - index0: inversion_found=0.
  - index1: inversion_found=1 (5>4).
  - With no further load_index, index stays 1 and the flag stays 1.
- Unsigned compare: SIGNED_CMP=0, write {0x00000001, 0xFFFFFFFF} -> no inversion; with SIGNED_CMP=1 the same data gives inversion_found=1.
- Boundaries:
  - length_in=0 and length_in=1 -> end_of_array=1 at index 0 and inversion_found=0.
  - length_in=40 -> length clamps to 32. Full scan reaches index 31 with end_of_array=1. A further increment holds index at 31.
- Mid-scan reset and write hazard:
  - Assert reset at index 3 -> index=0, end_of_array=1 asynchronously.
  - Separately, write mem[2] to below mem[1] while index=1 -> inversion_found becomes 1 in the cycle after the write edge.
